// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, FSM encoding and address-check helper for the fetch controller.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10
  } fetch_state_e;

  // Fetch address is illegal when misaligned or outside the inclusive text window.
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: exception > eret > redirect > pending redirect > sequential.
import fetch_ctrl_pkg::*;

module fetch_pc_sel #(
  parameter logic [31:0] EXC_PC = EXC_PC_DEF
) (
  input  logic [31:0] cur_pc,
  input  logic        advance,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        pend_valid,
  input  logic [31:0] pend_pc,
  output logic [31:0] next_pc,
  output logic        next_pend_valid,
  output logic [31:0] next_pend_pc
);

  // Select the next fetch address and the next pending-redirect state.
  always_comb begin
    next_pc         = cur_pc;
    next_pend_valid = pend_valid;
    next_pend_pc    = pend_pc;
    if (exc_req) begin
      next_pc         = EXC_PC;
      next_pend_valid = 1'b0;
    end else if (eret) begin
      next_pc         = epc;
      next_pend_valid = 1'b0;
    end else if (redirect_valid) begin
      if (advance) begin
        next_pc         = redirect_pc;
        next_pend_valid = 1'b0;
      end else begin
        // F/D frozen: remember the newest target until the fetch can move.
        next_pend_valid = 1'b1;
        next_pend_pc    = redirect_pc;
      end
    end else if (pend_valid && advance) begin
      next_pc         = pend_pc;
      next_pend_valid = 1'b0;
    end else if (advance) begin
      next_pc = cur_pc + 32'd4;
    end else begin
      next_pc = cur_pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: boot/fetch/wait FSM, fetch PC register and pending redirect.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter logic [31:0] TEXT_LO  = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] F_pc,
  output logic        imem_req,
  output logic        F_valid,
  output logic        F_adel
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         pend_valid_r;
  logic [31:0]  pend_pc_r;
  logic         imem_req_r;

  logic         advance_s;
  logic [31:0]  next_pc_s;
  logic         next_pend_valid_s;
  logic [31:0]  next_pend_pc_s;

  assign advance_s = (state_r != ST_BOOT) && imem_ready && !stall;

  fetch_pc_sel #(
    .EXC_PC (EXC_PC)
  ) u_pc_sel (
    .cur_pc          (pc_r),
    .advance         (advance_s),
    .exc_req         (exc_req),
    .eret            (eret),
    .epc             (epc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .pend_valid      (pend_valid_r),
    .pend_pc         (pend_pc_r),
    .next_pc         (next_pc_s),
    .next_pend_valid (next_pend_valid_s),
    .next_pend_pc    (next_pend_pc_s)
  );

  // FSM, PC and pending-redirect registers; reset discards any wait or pending target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
      imem_req_r   <= 1'b0;
    end else begin
      pc_r         <= next_pc_s;
      pend_valid_r <= next_pend_valid_s;
      pend_pc_r    <= next_pend_pc_s;
      // Every state reachable out of reset requests memory.
      imem_req_r   <= 1'b1;
      if (exc_req || eret) begin
        state_r <= ST_FETCH;
      end else begin
        case (state_r)
          ST_BOOT:  state_r <= ST_FETCH;
          ST_FETCH: state_r <= imem_ready ? ST_FETCH : ST_WAIT;
          ST_WAIT:  state_r <= imem_ready ? ST_FETCH : ST_WAIT;
          default:  state_r <= ST_BOOT;
        endcase
      end
    end
  end

  assign F_pc     = pc_r;
  assign imem_req = imem_req_r;
  assign F_valid  = advance_s;
  assign F_adel   = fetch_addr_err(pc_r, TEXT_LO, TEXT_HI);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] T_LO       = 32'h0000_3000;
  localparam logic [31:0] T_HI       = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] F_pc;
  logic        imem_req;
  logic        F_valid;
  logic        F_adel;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: PC, optional pending target, cycles since reset release.
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];
  int          m_since_rst;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .eret           (eret),
    .epc            (epc),
    .F_pc           (F_pc),
    .imem_req       (imem_req),
    .F_valid        (F_valid),
    .F_adel         (F_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] pc);
    return (pc % 32'd4 != 32'd0) || (pc < T_LO) || (pc > T_HI);
  endfunction

  // One cycle: drive inputs, check outputs mid-cycle against the model, clock, update model.
  task automatic step(input logic rst, input logic rdy, input logic stl,
                      input logic rv, input logic [31:0] rpc,
                      input logic exc, input logic er, input logic [31:0] ep);
    logic adv;
    reset = rst; imem_ready = rdy; stall = stl;
    redirect_valid = rv; redirect_pc = rpc;
    exc_req = exc; eret = er; epc = ep;
    @(negedge clk);
    adv = (m_since_rst > 0) && rdy && !stl;
    check("pc", F_pc, m_pc);
    check("req", {31'd0, imem_req}, {31'd0, m_since_rst > 0});
    check("valid", {31'd0, F_valid}, {31'd0, adv});
    check("adel", {31'd0, F_adel}, {31'd0, bad_addr(m_pc)});
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = T_RESET_PC;
      pend_q.delete();
      m_since_rst = 0;
    end else begin
      if (m_since_rst < 1000) m_since_rst++;
      if (exc) begin
        m_pc = T_EXC_PC;
        pend_q.delete();
      end else if (er) begin
        m_pc = ep;
        pend_q.delete();
      end else if (rv && adv) begin
        m_pc = rpc;
        pend_q.delete();
      end else if (rv) begin
        pend_q.delete();
        pend_q.push_back(rpc);
      end else if (adv && pend_q.size() > 0) begin
        m_pc = pend_q.pop_front();
      end else if (adv) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic go(input logic rdy, input logic stl);
    step(1'b0, rdy, stl, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic jump(input logic rdy, input logic stl, input logic [31:0] tgt);
    step(1'b0, rdy, stl, 1'b1, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic        r_rst, r_rdy, r_stl, r_rv, r_exc, r_er;
    logic [31:0] r_rpc, r_ep;

    // Two cycles of reset before any checking.
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; exc_req = 1'b0; eret = 1'b0; epc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = T_RESET_PC; m_since_rst = 0; pend_q.delete();

    // Boot then sequential fetch.
    check("rst_pc", F_pc, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_adel", {31'd0, F_adel}, 32'd0);
    go(1'b1, 1'b0);                       // BOOT cycle
    go(1'b1, 1'b0); check("seq0", F_pc, 32'h0000_3004);
    go(1'b1, 1'b0); check("seq1", F_pc, 32'h0000_3008);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0); check("at3010", F_pc, 32'h0000_3010);

    // Memory wait with a redirect arriving during the wait.
    go(1'b0, 1'b0);
    jump(1'b0, 1'b0, 32'h0000_3100);
    go(1'b0, 1'b0); check("wait_hold", F_pc, 32'h0000_3010);
    go(1'b1, 1'b0); check("wait_redir", F_pc, 32'h0000_3100);

    // Stall with two redirects; the newest wins.
    jump(1'b1, 1'b0, 32'h0000_3020); check("jmp3020", F_pc, 32'h0000_3020);
    jump(1'b1, 1'b1, 32'h0000_3200);
    go(1'b1, 1'b1);
    jump(1'b1, 1'b1, 32'h0000_3300); check("stall_hold", F_pc, 32'h0000_3020);
    go(1'b1, 1'b0); check("stall_redir", F_pc, 32'h0000_3300);

    // Exception beats a redirect while stalled and clears pending; then eret.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3400, 1'b1, 1'b0, 32'd0);
    check("exc", F_pc, 32'h0000_4180);
    go(1'b1, 1'b0); check("exc_nopend", F_pc, 32'h0000_4184);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_3024);
    check("eret", F_pc, 32'h0000_3024);

    // Address error cases.
    jump(1'b1, 1'b0, 32'h0000_3002); check("adel_misal", {31'd0, F_adel}, 32'd1);
    jump(1'b1, 1'b0, 32'h0000_7000); check("adel_hi", {31'd0, F_adel}, 32'd1);
    jump(1'b1, 1'b0, 32'h0000_6FFC); check("adel_edge", {31'd0, F_adel}, 32'd0);
    go(1'b1, 1'b0); check("wrap_pc", F_pc, 32'h0000_7000);
    check("wrap_adel", {31'd0, F_adel}, 32'd1);

    // Reset during a wait with a pending redirect.
    jump(1'b1, 1'b0, 32'h0000_3040);
    go(1'b0, 1'b0);
    jump(1'b0, 1'b0, 32'h0000_3500);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("mid_rst_pc", F_pc, 32'h0000_3000);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0); check("mid_rst_nopend", F_pc, 32'h0000_3004);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_stl = ($urandom_range(0, 3) == 0);
      r_rv  = ($urandom_range(0, 4) == 0);
      r_exc = ($urandom_range(0, 29) == 0);
      r_er  = ($urandom_range(0, 24) == 0);
      r_rpc = 32'h0000_2FF0 + ($urandom_range(0, 32'h4020) & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) == 0) r_rpc = $urandom;
      r_ep  = 32'h0000_3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
      step(r_rst, r_rdy, r_stl, r_rv, r_rpc, r_exc, r_er, r_ep);
    end

    // Sequential wrap-around at the top of the address space.
    jump(1'b1, 1'b0, 32'hFFFF_FFFC);
    go(1'b1, 1'b0); check("wrap32", F_pc, 32'h0000_0000);
    check("wrap32_adel", {31'd0, F_adel}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
